bist_truth_checker: RTL and testbench

- Synthesizable counterpart of the exhaustive truth-table stimulus bench, for on-chip self-test of small combinational blocks such as `teste`.
- It drives every input combination 0..2^N_IN-1 to the DUT and samples the DUT outputs after a settle interval.
- It compares each sample against a golden truth table parameter and reports pass/fail, the mismatch count and the first failing vector.
- It sits between a start/status controller and the combinational DUT.

---
 rtl/bist_truth_checker.sv | 130 +++++++++++++
 tb/tb_bist_truth_checker.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bist_truth_checker.sv
// Exhaustive truth-table self-test engine for a small combinational block.
// Sweeps every input vector, holds each one SETTLE_CYC+1 cycles, samples the
// block's response on the last hold cycle and compares it with GOLDEN.
//
// Handshake: start is a request, not a valid/ready pair. It is acted on only
// in IDLE or DONE (one edge launches a sweep) and is ignored while busy.
// Results (done/pass/fail_count/first_fail_*) are stable from the rise of
// done until the next accepted start or reset.
module bist_truth_checker #(
  parameter int                          N_IN       = 3,
  parameter int                          N_OUT      = 2,
  parameter int                          SETTLE_CYC = 1,
  parameter logic [N_OUT*(2**N_IN)-1:0]  GOLDEN     = 16'hE99C
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic [N_IN-1:0]   vec_out,
  input  logic [N_OUT-1:0]  resp_in,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [N_IN:0]     fail_count,
  output logic              first_fail_valid,
  output logic [N_IN-1:0]   first_fail_idx,
  output logic [1:0]        dbg_state
);

  // Hold counter must be at least one bit wide even when SETTLE_CYC is 0.
  localparam int HW = (SETTLE_CYC > 0) ? $clog2(SETTLE_CYC + 1) : 1;
  localparam int GW = $clog2(N_OUT * (2**N_IN));

  localparam logic [HW-1:0]   HOLD_LAST = HW'(SETTLE_CYC);
  localparam logic [HW-1:0]   HOLD_ONE  = HW'(1);
  localparam logic [N_IN-1:0] VEC_LAST  = {N_IN{1'b1}};
  localparam logic [N_IN-1:0] VEC_ONE   = N_IN'(1);
  localparam logic [N_IN:0]   FAIL_ONE  = (N_IN+1)'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_APPLY = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t            r_state;
  logic [HW-1:0]     r_hold;
  logic [N_IN-1:0]   r_vec;
  logic              r_busy;
  logic              r_done;
  logic [N_IN:0]     r_fail;
  logic              r_ff_valid;
  logic [N_IN-1:0]   r_ff_idx;

  logic [GW-1:0]     w_gidx;
  logic [N_OUT-1:0]  w_exp;
  logic              w_sample;
  logic              w_mismatch;

  // Golden response for the vector currently on vec_out.
  assign w_gidx     = GW'(r_vec) * GW'(N_OUT);
  assign w_exp      = GOLDEN[w_gidx +: N_OUT];
  assign w_sample   = (r_hold == HOLD_LAST);
  // Case inequality so an X/Z response is scored as a mismatch in simulation.
  assign w_mismatch = (resp_in !== w_exp);

  // Sweep controller: launch, hold/sample each vector, collect results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_hold     <= '0;
      r_vec      <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_fail     <= '0;
      r_ff_valid <= 1'b0;
      r_ff_idx   <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_state    <= S_APPLY;
            r_hold     <= '0;
            r_vec      <= '0;
            r_busy     <= 1'b1;
            r_done     <= 1'b0;
            r_fail     <= '0;
            r_ff_valid <= 1'b0;
            r_ff_idx   <= '0;
          end
        end
        S_APPLY: begin
          if (w_sample) begin
            if (w_mismatch) begin
              r_fail <= r_fail + FAIL_ONE;
              if (!r_ff_valid) begin
                r_ff_valid <= 1'b1;
                r_ff_idx   <= r_vec;
              end
            end
            if (r_vec == VEC_LAST) begin
              r_state <= S_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_vec  <= r_vec + VEC_ONE;
              r_hold <= '0;
            end
          end else begin
            r_hold <= r_hold + HOLD_ONE;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign vec_out          = r_vec;
  assign busy             = r_busy;
  assign done             = r_done;
  assign fail_count       = r_fail;
  assign first_fail_valid = r_ff_valid;
  assign first_fail_idx   = r_ff_idx;
  assign pass             = r_done && (r_fail == '0);
  assign dbg_state        = r_state;

endmodule

// File: tb/tb_bist_truth_checker.sv
// Bench for bist_truth_checker: a behavioural stand-in for the block under
// test (with selectable faults) feeds resp_in; expected results are the
// hand-derived values for F1=(x&y)|z, F2=x^y^z.
module tb_bist_truth_checker;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       start0 = 1'b0;
  int         mode = 0;

  logic [2:0] vec_out, vec_out0;
  logic [1:0] resp, resp0;
  logic       busy, done, pass, ffv;
  logic       busy0, done0, pass0, ffv0;
  logic [3:0] fail_count, fail_count0;
  logic [2:0] ffi, ffi0;
  logic [1:0] st, st0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Block under test: mode 0 healthy, 1 F2 stuck at 0, 2 F1 inverted at vector 6.
  function automatic logic [1:0] blk(input logic [2:0] v, input int m);
    logic x, y, z, f1, f2;
    {x, y, z} = v;
    f1 = (x & y) | z;
    f2 = x ^ y ^ z;
    if (m == 1) f2 = 1'b0;
    if (m == 2 && v == 3'd6) f1 = ~f1;
    return {f1, f2};
  endfunction

  assign resp  = blk(vec_out, mode);
  assign resp0 = blk(vec_out0, 2);

  bist_truth_checker #(.N_IN(3), .N_OUT(2), .SETTLE_CYC(1), .GOLDEN(16'hE99C)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .vec_out(vec_out), .resp_in(resp),
    .busy(busy), .done(done), .pass(pass), .fail_count(fail_count),
    .first_fail_valid(ffv), .first_fail_idx(ffi), .dbg_state(st)
  );

  bist_truth_checker #(.N_IN(3), .N_OUT(2), .SETTLE_CYC(0), .GOLDEN(16'hE99C)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .vec_out(vec_out0), .resp_in(resp0),
    .busy(busy0), .done(done0), .pass(pass0), .fail_count(fail_count0),
    .first_fail_valid(ffv0), .first_fail_idx(ffi0), .dbg_state(st0)
  );

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  // Count negedges with busy high (including the current one), bounded.
  task automatic wait_busy_end(output int n);
    n = 0;
    while (busy && n < 200) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({vec_out, busy, done, pass, fail_count, ffv, ffi, st} !== '0) begin
      errors++; $display("FAIL reset_dut: got %b want all zero",
                         {vec_out, busy, done, pass, fail_count, ffv, ffi, st});
    end
    checks++;
    if ({vec_out0, busy0, done0, pass0, fail_count0, ffv0, ffi0, st0} !== '0) begin
      errors++; $display("FAIL reset_dut0: got %b want all zero",
                         {vec_out0, busy0, done0, pass0, fail_count0, ffv0, ffi0, st0});
    end
    @(negedge clk) rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL idle_no_start: busy=%b done=%b want 0 0", busy, done);
    end
  endtask

  task automatic test_golden();
    int n;
    int vec_err;
    mode = 0;
    vec_err = 0;
    pulse_start();
    n = 0;
    while (busy && n < 200) begin
      if (vec_out !== 3'(n / 2)) vec_err++;
      n++;
      @(negedge clk);
    end
    checks++;
    if (vec_err != 0) begin
      errors++; $display("FAIL golden_vec_seq: %0d wrong vec_out samples, want 0", vec_err);
    end
    checks++;
    if (n != 16) begin errors++; $display("FAIL golden_busy_len: got %0d want 16", n); end
    checks++;
    if ({done, pass, fail_count, ffv} !== {1'b1, 1'b1, 4'd0, 1'b0}) begin
      errors++; $display("FAIL golden_result: done=%b pass=%b fc=%0d ffv=%b want 1 1 0 0",
                         done, pass, fail_count, ffv);
    end
    checks++;
    if (vec_out !== 3'd7) begin errors++; $display("FAIL golden_vec_hold: got %0d want 7", vec_out); end
    repeat (3) @(negedge clk);
    checks++;
    if ({done, pass, busy} !== 3'b110) begin
      errors++; $display("FAIL golden_hold: done=%b pass=%b busy=%b want 1 1 0", done, pass, busy);
    end
  endtask

  task automatic test_stuck_fault();
    int n;
    mode = 1;
    pulse_start();
    wait_busy_end(n);
    checks++;
    if (n != 16) begin errors++; $display("FAIL stuck_busy_len: got %0d want 16", n); end
    checks++;
    if ({done, pass, fail_count, ffv, ffi} !== {1'b1, 1'b0, 4'd4, 1'b1, 3'd1}) begin
      errors++; $display("FAIL stuck_result: done=%b pass=%b fc=%0d ffv=%b ffi=%0d want 1 0 4 1 1",
                         done, pass, fail_count, ffv, ffi);
    end
  endtask

  task automatic test_single_vector();
    int n;
    @(negedge clk) start0 = 1'b1;
    @(negedge clk) start0 = 1'b0;
    n = 0;
    while (busy0 && n < 200) begin
      n++;
      @(negedge clk);
    end
    checks++;
    if (n != 8) begin errors++; $display("FAIL single_busy_len: got %0d want 8", n); end
    checks++;
    if ({done0, pass0, fail_count0, ffv0, ffi0} !== {1'b1, 1'b0, 4'd1, 1'b1, 3'd6}) begin
      errors++; $display("FAIL single_result: done=%b pass=%b fc=%0d ffv=%b ffi=%0d want 1 0 1 1 6",
                         done0, pass0, fail_count0, ffv0, ffi0);
    end
  endtask

  task automatic test_reset_mid_sweep();
    int n;
    mode = 1;
    pulse_start();
    n = 0;
    while (vec_out !== 3'd3 && n < 200) begin
      n++;
      @(negedge clk);
    end
    checks++;
    if (n >= 200) begin errors++; $display("FAIL midrst_reach: vec_out=%0d never reached 3", vec_out); end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({vec_out, busy, done, pass, fail_count, ffv, ffi, st} !== '0) begin
      errors++; $display("FAIL midrst_clear: got %b want all zero",
                         {vec_out, busy, done, pass, fail_count, ffv, ffi, st});
    end
    @(negedge clk) rst_n = 1'b1;
    mode = 0;
    pulse_start();
    wait_busy_end(n);
    checks++;
    if (n != 16 || {done, pass, fail_count, ffv} !== {1'b1, 1'b1, 4'd0, 1'b0}) begin
      errors++; $display("FAIL midrst_rerun: busy=%0d done=%b pass=%b fc=%0d ffv=%b want 16 1 1 0 0",
                         n, done, pass, fail_count, ffv);
    end
  endtask

  task automatic test_start_while_busy();
    int n;
    bit injected;
    mode = 1;
    injected = 0;
    pulse_start();
    n = 0;
    while (busy && n < 200) begin
      if (start) start = 1'b0;
      else if (!injected && vec_out == 3'd5) begin start = 1'b1; injected = 1; end
      n++;
      @(negedge clk);
    end
    start = 1'b0;
    checks++;
    if (n != 16 || !injected) begin
      errors++; $display("FAIL busy_start_len: got %0d injected=%0d want 16 1", n, injected);
    end
    checks++;
    if ({done, fail_count, ffi} !== {1'b1, 4'd4, 3'd1}) begin
      errors++; $display("FAIL busy_start_result: done=%b fc=%0d ffi=%0d want 1 4 1", done, fail_count, ffi);
    end
  endtask

  task automatic test_restart_from_done();
    int n;
    // Previous task left a completed stuck-fault sweep in DONE.
    mode = 0;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    checks++;
    if ({done, busy, fail_count, ffv, vec_out} !== {1'b0, 1'b1, 4'd0, 1'b0, 3'd0}) begin
      errors++; $display("FAIL restart_edge: done=%b busy=%b fc=%0d ffv=%b vec=%0d want 0 1 0 0 0",
                         done, busy, fail_count, ffv, vec_out);
    end
    wait_busy_end(n);
    checks++;
    if (n != 16 || pass !== 1'b1) begin
      errors++; $display("FAIL restart_result: busy=%0d pass=%b want 16 1", n, pass);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    int done_cyc;
    mode = 0;
    @(negedge clk) start = 1'b1;
    n = 0;
    while (!busy && n < 200) begin n++; @(negedge clk); end
    wait_busy_end(n);
    done_cyc = 0;
    while (!busy && done_cyc < 50) begin
      if (done) done_cyc++;
      @(negedge clk);
    end
    start = 1'b0;
    checks++;
    if (done_cyc != 1) begin errors++; $display("FAIL b2b_done_gap: got %0d want 1", done_cyc); end
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      errors++; $display("FAIL b2b_resweep: busy=%b done=%b want 1 0", busy, done);
    end
    wait_busy_end(n);
    checks++;
    if (pass !== 1'b1) begin errors++; $display("FAIL b2b_final_pass: got %b want 1", pass); end
  endtask

  initial begin
    test_reset();
    test_golden();
    test_stuck_fault();
    test_single_vector();
    test_reset_mid_sweep();
    test_start_while_busy();
    test_restart_from_done();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
